// File: rtl/mdu_pkg.sv
// Shared encodings and sizing helpers for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int MDU_N = 32;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } mdop_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    SIGN = 2'b10
  } state_e;

  // The counter must hold the value n itself, hence the extra bit.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int MDU_CNT_W = cnt_width(MDU_N);

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_cond_neg.sv
// Conditional two's-complement negation: y = neg ? -x : x.
module cond_neg #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one bit per cycle on magnitudes,
// sign fix-up in a final cycle, results held in HI/LO until the next completion.
module mdu
  import mdu_pkg::*;
#(
  parameter int N = MDU_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   mdop,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         divz
);

  localparam int CW = cnt_width(N);

  state_e         state_q;
  mdop_e          op_q;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   wh_q;
  logic [N-1:0]   wl_q;
  logic [N-1:0]   wb_q;
  logic           neg_q_q;
  logic           neg_r_q;
  logic           zero_q;
  logic           busy_q;
  logic           done_q;
  logic           divz_q;
  logic [N-1:0]   hi_q;
  logic [N-1:0]   lo_q;

  logic           a_neg_s;
  logic           b_neg_s;
  logic [N-1:0]   a_mag_s;
  logic [N-1:0]   b_mag_s;
  logic [N:0]     add_s;
  logic [N:0]     mul_s;
  logic [N:0]     shl_s;
  logic [N:0]     trial_s;
  logic [N-1:0]   wh_d;
  logic [N-1:0]   wl_d;
  logic [2*N-1:0] prod_fix_s;
  logic [N-1:0]   quo_fix_s;
  logic [N-1:0]   rem_fix_s;

  assign a_neg_s = op_is_signed(mdop) & a[N-1];
  assign b_neg_s = op_is_signed(mdop) & b[N-1];

  cond_neg #(.W(N)) u_abs_a (.neg(a_neg_s), .x(a), .y(a_mag_s));
  cond_neg #(.W(N)) u_abs_b (.neg(b_neg_s), .x(b), .y(b_mag_s));

  cond_neg #(.W(2*N)) u_neg_prod (.neg(neg_q_q), .x({wh_q, wl_q}), .y(prod_fix_s));
  cond_neg #(.W(N))   u_neg_quo  (.neg(neg_q_q), .x(wl_q),         .y(quo_fix_s));
  cond_neg #(.W(N))   u_neg_rem  (.neg(neg_r_q), .x(wh_q),         .y(rem_fix_s));

  // One shift-add (multiply) or restoring-subtract (divide) step.
  always_comb begin
    add_s   = {1'b0, wh_q} + {1'b0, wb_q};
    mul_s   = wl_q[0] ? add_s : {1'b0, wh_q};
    shl_s   = {wh_q, wl_q[N-1]};
    trial_s = shl_s - {1'b0, wb_q};
    wh_d    = wh_q;
    wl_d    = wl_q;
    if (op_is_div(op_q)) begin
      // Borrow out of the trial subtraction means the divisor did not fit.
      wh_d = trial_s[N] ? shl_s[N-1:0] : trial_s[N-1:0];
      wl_d = {wl_q[N-2:0], ~trial_s[N]};
    end else begin
      wh_d = mul_s[N:1];
      wl_d = {mul_s[0], wl_q[N-1:1]};
    end
  end

  // Control FSM, working registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= MD_MULTU;
      cnt_q   <= {CW{1'b0}};
      wh_q    <= {N{1'b0}};
      wl_q    <= {N{1'b0}};
      wb_q    <= {N{1'b0}};
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
      hi_q    <= {N{1'b0}};
      lo_q    <= {N{1'b0}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= mdop_e'(mdop);
            cnt_q   <= CW'(N);
            wh_q    <= {N{1'b0}};
            wl_q    <= a_mag_s;
            wb_q    <= b_mag_s;
            neg_q_q <= a_neg_s ^ b_neg_s;
            neg_r_q <= a_neg_s;
            zero_q  <= (b == {N{1'b0}});
            divz_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          wh_q  <= wh_d;
          wl_q  <= wl_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= SIGN;
          end
        end
        SIGN: begin
          if (op_is_div(op_q)) begin
            // Zero divisor: remainder path already yields a, quotient forced to all ones.
            hi_q   <= rem_fix_s;
            lo_q   <= zero_q ? {N{1'b1}} : quo_fix_s;
            divz_q <= zero_q;
          end else begin
            hi_q <= prod_fix_s[2*N-1:N];
            lo_q <= prod_fix_s[N-1:0];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign divz = divz_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed and random operations against an arithmetic model.
module tb_mdu;

  localparam int LAT = 34;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mdop;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        divz;

  int n_checks = 0;
  int n_fail   = 0;

  mdu #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mdop(mdop), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .divz(divz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the architectural definition.
  task automatic model(input logic [1:0] op, input logic [31:0] ma, input logic [31:0] mb,
                       output logic [31:0] ehi, output logic [31:0] elo, output logic edz);
    logic [63:0] p;
    longint sp;
    int sa, sb;
    edz = 1'b0;
    ehi = 32'd0;
    elo = 32'd0;
    sa = $signed(ma);
    sb = $signed(mb);
    case (op)
      2'b00: begin p = {32'd0, ma} * {32'd0, mb}; ehi = p[63:32]; elo = p[31:0]; end
      2'b01: begin sp = longint'(sa) * longint'(sb); p = sp; ehi = p[63:32]; elo = p[31:0]; end
      default: begin
        if (mb == 32'd0) begin
          edz = 1'b1; elo = 32'hFFFF_FFFF; ehi = ma;
        end else if (op == 2'b10) begin
          elo = ma / mb; ehi = ma % mb;
        end else if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
          elo = 32'h8000_0000; ehi = 32'd0;
        end else begin
          elo = sa / sb; ehi = sa % sb;
        end
      end
    endcase
  endtask

  // Issue one op from just after a clock edge; return at the first cycle with done seen.
  // lat counts rising edges from the accepting edge inclusive; poke>0 pulses start then.
  task automatic do_op(input logic [1:0] op, input logic [31:0] oa, input logic [31:0] ob,
                       input int poke, output int lat, output int hold_bad, output int busy_bad);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    hold_bad = 0; busy_bad = 0;
    start = 1'b1; mdop = op; a = oa; b = ob;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 3 * LAT) begin
      if (busy !== 1'b1) busy_bad++;
      if (hi !== h0 || lo !== l0) hold_bad++;
      if (lat == poke) begin
        start = 1'b1; mdop = ~op; a = ~oa; b = oa ^ ob;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
  endtask

  task automatic check_op(input string name, input logic [1:0] op, input logic [31:0] oa,
                          input logic [31:0] ob, input int poke);
    logic [31:0] ehi, elo;
    logic edz;
    int lat, hb, bb;
    model(op, oa, ob, ehi, elo, edz);
    do_op(op, oa, ob, poke, lat, hb, bb);
    n_checks++;
    if (lat !== LAT || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s latency: got lat=%0d done=%b busy=%b, want lat=%0d done=1 busy=0",
               name, lat, done, busy, LAT);
    end
    n_checks++;
    if (hi !== ehi || lo !== elo || divz !== edz) begin
      n_fail++;
      $display("FAIL %s result: got hi=%h lo=%h divz=%b, want hi=%h lo=%h divz=%b",
               name, hi, lo, divz, ehi, elo, edz);
    end
    n_checks++;
    if (hb !== 0 || bb !== 0) begin
      n_fail++;
      $display("FAIL %s in-flight: got hold_errs=%0d busy_errs=%0d, want 0 and 0", name, hb, bb);
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || divz !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got busy=%b done=%b hi=%h lo=%h divz=%b, want all zero",
               busy, done, hi, lo, divz);
    end
  endtask

  task automatic test_directed;
    check_op("multu_max",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check_op("mult_neg",   2'b01, 32'hFFFF_FFF9, 32'd6, 0);
    check_op("div_neg",    2'b11, 32'hFFFF_FFF9, 32'd2, 0);
    check_op("divu_small", 2'b10, 32'd100, 32'd7, 0);
    check_op("div_ovf",    2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check_op("mult_minsq", 2'b01, 32'h8000_0000, 32'h8000_0000, 0);
    check_op("div_by0",    2'b11, 32'hFFFF_FF00, 32'd0, 0);
  endtask

  task automatic test_divz_clear;
    check_op("divu_by0", 2'b10, 32'h0000_1234, 32'd0, 0);
    start = 1'b1; mdop = 2'b00; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (divz !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL divz_clear: got divz=%b busy=%b, want divz=0 busy=1", divz, busy);
    end
    while (!done) begin @(posedge clk); #1; end
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd15) begin
      n_fail++;
      $display("FAIL divz_clear_res: got hi=%h lo=%h, want 0 and f", hi, lo);
    end
  endtask

  task automatic test_ignore_start;
    // Fifth CALC cycle: after E0 is CALC cycle 1 (lat=1), so poke at lat=5.
    check_op("ignore_start", 2'b10, 32'd1000, 32'd33, 5);
  endtask

  task automatic test_back_to_back;
    check_op("b2b_first",  2'b01, 32'h1234_5678, 32'hFEDC_BA98, 0);
    check_op("b2b_second", 2'b11, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 0);
  endtask

  task automatic test_random;
    logic [1:0] op;
    logic [31:0] ra, rb;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      check_op("random", op, ra, rb, 0);
    end
  endtask

  task automatic test_reset_mid;
    start = 1'b1; mdop = 2'b01; a = 32'hDEAD_BEEF; b = 32'h0000_0777;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || divz !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h divz=%b, want all zero",
               busy, done, hi, lo, divz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
    check_op("after_reset", 2'b10, 32'hFFFF_FFFF, 32'd10, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mdop = 2'b00; a = 32'd0; b = 32'd0;
    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset;
    test_directed;
    test_divz_clear;
    test_ignore_start;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit for the MIPS datapath, the sequential companion to the single-cycle ALU. It executes MULT, MULTU, DIV and DIVU on n-bit operands one bit per cycle. It holds the results in HI/LO registers for MFHI/MFLO and signals progress through a start/busy/done handshake so the control unit can stall.

## Interface
- n, 32: operand and result width, must be ≥ 4.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- mdop  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  input  n  multiplicand / dividend.
- b  input  n  multiplier / divisor.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when hi/lo become valid.
- hi  output  n  product upper half / remainder.
- lo  output  n  product lower half / quotient.
- divz  output  1  last division had b == 0; held until next accepted start.

## Operation
- Reset (asynchronous, any time, including mid-operation): state IDLE, busy=0, done=0, hi=0, lo=0, divz=0, counter=0. Any in-flight operation is discarded.
- States:
  - IDLE: on start=1, latch mdop, latch |a| and |b| (signed ops) or a and b (unsigned ops), record the result signs, load counter=n, clear divz, go to CALC.
  - CALC: one iteration per cycle; the counter decrements; when counter reaches 1 on this cycle, go to SIGN.
  - SIGN: apply sign correction, write hi/lo, pulse done, go to IDLE.
- Multiply: shift-add over a 2n-bit accumulator {hi,lo}. For MULT, negate the 2n-bit product if sign(a) ≠ sign(b).
- Divide: restoring division. Remainder in hi, quotient in lo.
  - DIV: quotient negated if operand signs differ; remainder takes the sign of the dividend.
  - DIV of most-negative by −1: lo = most-negative, hi = 0 (two's-complement wrap, no flag).
- Divide by zero (b == 0, DIVU or DIV): divz=1, lo = all ones, hi = a unchanged. Normal latency is kept; no early exit.
- hi/lo hold their values from the SIGN write until the next SIGN write. They are not altered during CALC from the outside view; internal working registers are separate.
- start while busy=1 is ignored; no queueing.

## Timing
- Edge E0 samples start=1 in IDLE.
- busy=1 from after E0 through the SIGN cycle.
- CALC occupies n cycles and SIGN occupies 1 cycle.
- done=1 and busy=0 in the cycle after SIGN, i.e. n+2 cycles after E0 (34 for n=32). hi/lo/divz are valid in that same cycle.
- done lasts exactly one cycle. A start asserted during the done cycle is accepted (FSM is already IDLE), giving back-to-back throughput of one operation per n+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package mdu_pkg:
  - mdop encodings: MD_MULTU, MD_MULT, MD_DIVU, MD_DIV.
  - state enum: IDLE, CALC, SIGN.
  - counter width constant: $clog2(n)+1.
- One sub-module: cond_neg (parameter w). Outputs x or −x based on a select. It is instantiated for operand magnitude (w=n), product negation (w=2n), and quotient/remainder fix-up (w=n).

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 34 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001, divz=0.
- MULT a=−7 (0xFFFFFFF9), b=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6.
- DIV a=−7, b=2 -> lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=0x1234, b=0 -> divz=1, lo=0xFFFFFFFF, hi=0x1234. The next MULTU clears divz at acceptance.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Handshake/reset:
  - start pulsed at cycle 5 of CALC -> ignored, result unchanged.
  - start during the done cycle -> accepted; the next done arrives 34 cycles later.
  - rst_n dropped mid-CALC -> outputs immediately 0, IDLE; a new start then completes normally.
